// File: rtl/id_stage_core_if.sv
// -----------------------------------------------------------------------------
// id_stage_core_if
// Signal bundle between the surrounding pipeline (IF/ID, MEM, WB) and the
// instruction-decode datapath id_stage_core.
//
// Signals (direction as seen by the decode stage, i.e. the slave modport):
//   RegWrite        in   register-file write enable from WB control
//   instruction     in   IF/ID instruction word
//   write_reg       in   write-back destination register index
//   write_data_reg  in   write-back data
//   fw_rs / fw_rt   in   select alu_result_mem instead of the rs / rt read data
//   pcPlus4         in   PC+4 of the instruction in ID
//   alu_result_mem  in   MEM-stage ALU result (forwarding source)
//   inst_extended   out  sign-extended instruction[15:0]
//   read_data1_reg  out  rs operand after forwarding
//   read_data2_reg  out  rt operand after forwarding
//   branch_adder_id out  branch target
//   zero            out  1 when both forwarded operands are equal
//
// Handshake: none. Every signal is a plain level that is valid every cycle;
// the decode outputs follow their inputs combinationally, and only the
// register-file write is committed on the rising clock edge.
// -----------------------------------------------------------------------------
interface id_stage_core_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  RegWrite;
    logic [31:0]           instruction;
    logic [4:0]            write_reg;
    logic [DATA_WIDTH-1:0] write_data_reg;
    logic                  fw_rs;
    logic                  fw_rt;
    logic [DATA_WIDTH-1:0] pcPlus4;
    logic [DATA_WIDTH-1:0] alu_result_mem;
    logic [DATA_WIDTH-1:0] inst_extended;
    logic [DATA_WIDTH-1:0] read_data1_reg;
    logic [DATA_WIDTH-1:0] read_data2_reg;
    logic [DATA_WIDTH-1:0] branch_adder_id;
    logic                  zero;

    // Pipeline side: drives the decode inputs, observes its results.
    modport master (
        output RegWrite, instruction, write_reg, write_data_reg,
               fw_rs, fw_rt, pcPlus4, alu_result_mem,
        input  inst_extended, read_data1_reg, read_data2_reg,
               branch_adder_id, zero
    );

    // Decode stage side.
    modport slave (
        input  RegWrite, instruction, write_reg, write_data_reg,
               fw_rs, fw_rt, pcPlus4, alu_result_mem,
        output inst_extended, read_data1_reg, read_data2_reg,
               branch_adder_id, zero
    );
endinterface

// File: rtl/id_stage_core.sv
// -----------------------------------------------------------------------------
// id_stage_core
// Instruction-decode stage datapath of a 5-stage MIPS pipeline: 32x32 register
// file, 16->32 sign extension, branch-target adder, rs/rt forwarding muxes fed
// from the MEM-stage ALU result, and the equality comparator used for early
// branch resolution.
//
// Ports:
//   clk  in  rising-edge clock; the register file is the only state
//   rst  in  synchronous active-high reset, clears all 32 registers and wins
//            over a write presented on the same edge
//   bus  id_stage_core_if.slave, see the interface file for the signal list
//
// Optional feature (macro ID_WRITE_BYPASS_EN):
//   defined   - a write presented this cycle (RegWrite=1, rst=0, non-zero
//               index) is returned combinationally on a matching rs/rt read;
//               fw_rs/fw_rt still override it.
//   undefined - reads show the stored register contents only.
//
// All outputs are combinational; there are no output registers.
// -----------------------------------------------------------------------------
module id_stage_core #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input logic           clk,
    input logic           rst,
    id_stage_core_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;
    logic [DATA_WIDTH-1:0] rf_data1;
    logic [DATA_WIDTH-1:0] rf_data2;
    logic [DATA_WIDTH-1:0] ext;
    logic [DATA_WIDTH-1:0] ext_shifted;

    assign rs = bus.instruction[25:21];
    assign rt = bus.instruction[20:16];

    // Opcode bits are decoded by the control unit, not here.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, bus.instruction[31:26]};

    // Register file. Index 0 is never written, so it only ever holds the
    // reset value; reads of index 0 are forced to zero regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.RegWrite && (bus.write_reg != 5'd0)) begin
            regs[bus.write_reg] <= bus.write_data_reg;
        end
    end

    assign stored1 = (rs == 5'd0) ? '0 : regs[rs];
    assign stored2 = (rt == 5'd0) ? '0 : regs[rt];

`ifdef ID_WRITE_BYPASS_EN
    // Write-through: a write committing at the next edge is already visible.
    logic bypass_live;
    assign bypass_live = bus.RegWrite && !rst && (bus.write_reg != 5'd0);
    assign rf_data1 = (bypass_live && (bus.write_reg == rs)) ? bus.write_data_reg : stored1;
    assign rf_data2 = (bypass_live && (bus.write_reg == rt)) ? bus.write_data_reg : stored2;
`else
    assign rf_data1 = stored1;
    assign rf_data2 = stored2;
`endif

    // MEM-stage forwarding sits after the register file (and after the
    // optional write-through), so it always has the final say.
    assign bus.read_data1_reg = bus.fw_rs ? bus.alu_result_mem : rf_data1;
    assign bus.read_data2_reg = bus.fw_rt ? bus.alu_result_mem : rf_data2;

    // Early branch resolution compares the post-forwarding operands.
    assign bus.zero = (bus.read_data1_reg == bus.read_data2_reg);

    assign ext               = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
    assign bus.inst_extended = ext;

    // Word offset: the two top sign copies fall off, two zero LSBs come in.
    // Carry-out of the add is dropped, so targets wrap modulo 2^32.
    assign ext_shifted         = {ext[DATA_WIDTH-3:0], 2'b00};
    assign bus.branch_adder_id = bus.pcPlus4 + ext_shifted;

endmodule

// File: tb/tb_id_stage_core.sv
// -----------------------------------------------------------------------------
// tb_id_stage_core
// Directed bench for id_stage_core: reset, register writes (including r0 and
// disabled writes), sign extension and branch target (including wrap-around),
// forwarding priority, reset-vs-write priority and same-cycle write/read.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_id_stage_core;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    id_stage_core_if #(.DATA_WIDTH(32)) bus ();

    id_stage_core #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then step clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        bus.RegWrite       = 1'b1;
        bus.write_reg      = idx;
        bus.write_data_reg = data;
        tick();
        bus.RegWrite       = 1'b0;
    endtask

    logic [31:0] same_cycle_exp;

    initial begin
        total = 0;
        bad   = 0;
        rst                = 1'b1;
        bus.RegWrite       = 1'b0;
        bus.instruction    = 32'h0;
        bus.write_reg      = 5'd0;
        bus.write_data_reg = 32'h0;
        bus.fw_rs          = 1'b0;
        bus.fw_rt          = 1'b0;
        bus.pcPlus4        = 32'h0;
        bus.alu_result_mem = 32'h0;
        tick();
        rst = 1'b0;

        // After reset, rs=1 rt=2 read zero and compare equal.
        bus.instruction = 32'h0022_1820;
        #1;
        check("rst_rd1", bus.read_data1_reg, 32'h0);
        check("rst_rd2", bus.read_data2_reg, 32'h0);
        check("rst_zero", {31'b0, bus.zero}, 32'h1);
        check("ext_pos_small", bus.inst_extended, 32'h0000_1820);
        check("br_pc0", bus.branch_adder_id, 32'h0000_6080);

        // Write r1.
        write_reg(5'd1, 32'h0000_00AA);
        #1;
        check("wr_r1_rd1", bus.read_data1_reg, 32'h0000_00AA);
        check("wr_r1_zero", {31'b0, bus.zero}, 32'h0);

        // Write to r0 is discarded.
        write_reg(5'd0, 32'hFFFF_FFFF);
        bus.instruction = 32'h0000_0000;
        #1;
        check("r0_rd1", bus.read_data1_reg, 32'h0);
        check("r0_zero", {31'b0, bus.zero}, 32'h1);

        // RegWrite=0 leaves r5 untouched.
        bus.RegWrite       = 1'b0;
        bus.write_reg      = 5'd5;
        bus.write_data_reg = 32'h5555_5555;
        tick();
        bus.instruction = 32'h00A0_0000;
        #1;
        check("nowr_r5", bus.read_data1_reg, 32'h0);

        // Sign extension and branch target.
        bus.pcPlus4     = 32'h0000_1000;
        bus.instruction = 32'h0022_8000;
        #1;
        check("ext_neg", bus.inst_extended, 32'hFFFF_8000);
        check("br_neg", bus.branch_adder_id, 32'hFFFE_1000);
        bus.instruction = 32'h0022_0004;
        #1;
        check("ext_pos", bus.inst_extended, 32'h0000_0004);
        check("br_pos", bus.branch_adder_id, 32'h0000_1010);
        bus.pcPlus4     = 32'hFFFF_FFF0;
        bus.instruction = 32'h0022_7FFF;
        #1;
        check("ext_max", bus.inst_extended, 32'h0000_7FFF);
        check("br_wrap", bus.branch_adder_id, 32'h0001_FFEC);

        // Forwarding.
        write_reg(5'd2, 32'h0000_0055);
        bus.instruction    = 32'h0022_1820;
        #1;
        check("r2_rd2", bus.read_data2_reg, 32'h0000_0055);
        bus.fw_rs          = 1'b1;
        bus.alu_result_mem = 32'h0000_0055;
        #1;
        check("fwrs_rd1", bus.read_data1_reg, 32'h0000_0055);
        check("fwrs_zero", {31'b0, bus.zero}, 32'h1);
        bus.fw_rt = 1'b1;
        #1;
        check("fwboth_rd1", bus.read_data1_reg, 32'h0000_0055);
        check("fwboth_rd2", bus.read_data2_reg, 32'h0000_0055);
        check("fwboth_zero", {31'b0, bus.zero}, 32'h1);
        bus.fw_rs          = 1'b0;
        bus.alu_result_mem = 32'h0000_00AA;
        #1;
        check("fwrt_rd1", bus.read_data1_reg, 32'h0000_00AA);
        check("fwrt_rd2", bus.read_data2_reg, 32'h0000_00AA);
        check("fwrt_zero", {31'b0, bus.zero}, 32'h1);
        bus.alu_result_mem = 32'h0000_0099;
        #1;
        check("fwrt_ne_zero", {31'b0, bus.zero}, 32'h0);
        bus.instruction    = 32'h0000_0000;
        bus.fw_rs          = 1'b1;
        bus.fw_rt          = 1'b0;
        bus.alu_result_mem = 32'h0000_0077;
        #1;
        check("fw_r0_rd1", bus.read_data1_reg, 32'h0000_0077);
        check("fw_r0_rd2", bus.read_data2_reg, 32'h0);
        bus.fw_rs = 1'b0;

        // Reset wins over a simultaneous write; r1 is cleared too.
        rst                = 1'b1;
        bus.RegWrite       = 1'b1;
        bus.write_reg      = 5'd3;
        bus.write_data_reg = 32'h0000_1234;
        tick();
        rst          = 1'b0;
        bus.RegWrite = 1'b0;
        bus.instruction = 32'h0061_0000;
        #1;
        check("rstwr_r3", bus.read_data1_reg, 32'h0);
        check("rstwr_r1", bus.read_data2_reg, 32'h0);

        // Same-cycle write and read of r4.
`ifdef ID_WRITE_BYPASS_EN
        same_cycle_exp = 32'h0000_BEEF;
`else
        same_cycle_exp = 32'h0;
`endif
        bus.instruction    = 32'h0084_0000;
        bus.RegWrite       = 1'b1;
        bus.write_reg      = 5'd4;
        bus.write_data_reg = 32'h0000_BEEF;
        #1;
        check("same_cyc_rd1", bus.read_data1_reg, same_cycle_exp);
        bus.fw_rt          = 1'b1;
        bus.alu_result_mem = 32'h0000_0011;
        #1;
        check("same_cyc_fw_rd2", bus.read_data2_reg, 32'h0000_0011);
        bus.fw_rt = 1'b0;
        tick();
        bus.RegWrite = 1'b0;
        #1;
        check("post_edge_rd1", bus.read_data1_reg, 32'h0000_BEEF);
        check("post_edge_rd2", bus.read_data2_reg, 32'h0000_BEEF);
        check("post_edge_zero", {31'b0, bus.zero}, 32'h1);

        // Highest register index.
        write_reg(5'd31, 32'hDEAD_BEEF);
        bus.instruction = 32'h03E4_0000;
        #1;
        check("r31_rd1", bus.read_data1_reg, 32'hDEAD_BEEF);
        check("r31_rd2", bus.read_data2_reg, 32'h0000_BEEF);
        check("r31_zero", {31'b0, bus.zero}, 32'h0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage_core.md
Name: id_stage_core

Overview:
- Instruction-decode stage datapath of the 5-stage MIPS pipeline, between the IF/ID and ID/EX pipeline registers.
- Contains the 32x32 register file and the 16-to-32 sign extension.
- Contains the branch-target adder, rs/rt forwarding muxes from the MEM-stage ALU result, and the equality comparator used for early branch resolution.

Parameters:
- DATA_WIDTH, 32, width of datapath, registers, PC and immediate extension result (fixed at 32 for MIPS; other values unsupported).
- NUM_REGS, 32, register count; address width is 5 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- RegWrite  input  1  register-file write enable (from WB control).
- instruction  input  32  IF/ID instruction word.
- write_reg  input  5  destination register index for write-back.
- write_data_reg  input  32  write-back data.
- fw_rs  input  1  1 = replace rs read data with alu_result_mem.
- fw_rt  input  1  1 = replace rt read data with alu_result_mem.
- pcPlus4  input  32  PC+4 of the instruction in ID.
- alu_result_mem  input  32  ALU result currently in MEM stage (forward source).
- inst_extended  output  32  sign-extended instruction[15:0].
- read_data1_reg  output  32  rs operand after forwarding mux.
- read_data2_reg  output  32  rt operand after forwarding mux.
- branch_adder_id  output  32  branch target.
- zero  output  1  1 when forwarded operands are equal.

Behaviour:
- Register source indices:
  - rs = instruction[25:21].
  - rt = instruction[20:16].
- Register file:
  - 32 registers of 32 bits.
  - Reads are combinational and asynchronous.
  - Write on rising clk when RegWrite=1 and rst=0.
  - Register 0 always reads 0; writes to index 0 are discarded.
- Reset:
  - On a rising edge with rst=1, all 32 registers clear to 0.
  - Reset has priority over a simultaneous write; that write is lost.
  - Reset asserted mid-sequence clears all registers at that edge; no partial state is kept.
- Outputs:
  - All outputs are combinational; there are no output registers.
  - After reset, read_data1_reg = read_data2_reg = 0 unless forwarded, and zero=1 when neither operand is forwarded.
- Sign extension:
  - inst_extended = {16{instruction[15]}, instruction[15:0]}.
- Branch adder:
  - branch_adder_id = pcPlus4 + (inst_extended << 2), modulo 2^32.
  - Carry-out is discarded and wrap-around is permitted.
  - The shift drops inst_extended[31:30] and inserts two zero LSBs.
- Forwarding:
  - read_data1_reg = fw_rs ? alu_result_mem : regfile[rs].
  - read_data2_reg = fw_rt ? alu_result_mem : regfile[rt].
  - Forwarding applies even when rs/rt = 0.
- Comparator: zero = (read_data1_reg == read_data2_reg), computed on the post-mux values.
- Same-cycle write and read of the same register (default): the read returns the old value until the rising edge, then the new value. See optional feature for the alternative.
- Latency:
  - A write is visible on reads combinationally after the committing clock edge.
  - Every other path is zero-cycle combinational.

Optional Feature:
- Macro: ID_WRITE_BYPASS_EN.
- Defined:
  - When RegWrite=1, rst=0, write_reg!=0 and write_reg equals rs (or rt), that register-file read returns write_data_reg combinationally in the same cycle.
  - The bypass feeds the forwarding mux, so fw_rs/fw_rt still take priority.
- Undefined: no internal bypass; reads show stored contents only.

Test Plan:
- Reset, then write sequence:
  - Assert rst for 1 edge, then instruction=0x00221820 (rs=1, rt=2) → read_data1_reg=0, read_data2_reg=0, zero=1.
  - Write r1=0x0000_00AA (RegWrite=1, write_reg=1) → after edge, read_data1_reg=0xAA, zero=0.
- Write r0=0xFFFF_FFFF → reading rs=0 still returns 0; write with RegWrite=0 to r5 → r5 unchanged.
- Sign extension and branch target:
  - instruction[15:0]=0x8000 with pcPlus4=0x0000_1000 → inst_extended=0xFFFF_8000, branch_adder_id=0xFFFE_1000.
  - instruction[15:0]=0x0004 → inst_extended=0x4, branch_adder_id=0x0000_1010.
- Forwarding: r1=0xAA, r2=0x55, fw_rs=1, alu_result_mem=0x55 → read_data1_reg=0x55, zero=1; fw_rt=1 as well → both 0x55, zero=1.
- Simultaneous rst=1 and RegWrite=1 to r3=0x1234 → after edge r3=0.
- Same-cycle write/read of r4=0xBEEF:
  - Read before the edge returns old value 0 without ID_WRITE_BYPASS_EN.
  - Read returns 0xBEEF immediately with ID_WRITE_BYPASS_EN defined.
